// File: rtl/dp_pkg.sv
// Shared encodings for the parametrised datapath:
// ALU opcodes, bus selects, read FSM states, CCR bit positions.
package dp_pkg;

    // ADD/SUB use A and B; INC/DEC/PASS use A only.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_INC  = 4'd5;
    localparam logic [3:0] ALU_DEC  = 4'd6;
    localparam logic [3:0] ALU_PASS = 4'd7;

    localparam logic [1:0] BUS1_PC  = 2'b00;
    localparam logic [1:0] BUS1_REG = 2'b01;
    localparam logic [1:0] BUS1_MDR = 2'b10;
    localparam logic [1:0] BUS1_SP  = 2'b11;

    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MDR  = 2'b10;
    localparam logic [1:0] BUS2_ZERO = 2'b11;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

endpackage

// File: rtl/data_path_param_alu.sv
// Combinational ALU: result plus NZVC flags.
// C is carry-out for additions and borrow for subtractions.
module dp_alu
    import dp_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int M = DATA_W - 1;

    logic [DATA_W:0] wide;
    logic            v;
    logic            c;

    always_comb begin
        wide   = '0;
        result = '0;
        v      = 1'b0;
        c      = 1'b0;
        case (op)
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[M:0];
                c      = wide[DATA_W];
                v      = (a[M] == b[M]) && (result[M] != a[M]);
            end
            ALU_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[M:0];
                c      = wide[DATA_W];
                v      = (a[M] != b[M]) && (result[M] != a[M]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_INC: begin
                wide   = {1'b0, a} + (DATA_W+1)'(1);
                result = wide[M:0];
                c      = wide[DATA_W];
                v      = !a[M] && result[M];
            end
            ALU_DEC: begin
                wide   = {1'b0, a} - (DATA_W+1)'(1);
                result = wide[M:0];
                c      = wide[DATA_W];
                v      = a[M] && !result[M];
            end
            ALU_PASS: result = a;
            default:  result = '0;
        endcase
        flags        = '0;
        flags[CCR_N] = result[M];
        flags[CCR_Z] = (result == '0);
        flags[CCR_V] = v;
        flags[CCR_C] = c;
    end

endmodule

// File: rtl/data_path_param.sv
// Parametrised microcontroller datapath: IR/MAR/PC/SP/MDR/Rn/CCR,
// two buses, ALU, stack pointer and a stalling memory-read handshake.
module data_path_param
    import dp_pkg::*;
#(
    parameter  int               DATA_W = 8,
    parameter  int               ADDR_W = 8,
    parameter  int               NREGS  = 4,
    parameter  logic [ADDR_W-1:0] SP_TOP = '1,
    localparam int               RSEL_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ir_load,
    input  logic              mar_load,
    input  logic              pc_load,
    input  logic              pc_inc,
    input  logic              ccr_load,
    input  logic              pc_rel,
    input  logic              reg_wr_en,
    input  logic [RSEL_W-1:0] reg_wr_sel,
    input  logic [RSEL_W-1:0] reg_rd_sel,
    input  logic [RSEL_W-1:0] alu_b_reg_sel,
    input  logic [1:0]        bus1_sel,
    input  logic [1:0]        bus2_sel,
    input  logic [3:0]        alu_sel,
    input  logic              alu_b_sel,
    input  logic              sp_push,
    input  logic              sp_pop,
    input  logic              mem_rd,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] from_memory,
    output logic [DATA_W-1:0] to_memory,
    output logic              mem_req,
    output logic              stall,
    output logic              mdr_valid,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] sp,
    output logic [3:0]        ccr,
    output logic              stack_err
);

    if (ADDR_W > DATA_W) begin : g_bad_addr_w
        $error("data_path_param: ADDR_W must not exceed DATA_W");
    end
    if (NREGS < 2) begin : g_bad_nregs
        $error("data_path_param: NREGS must be at least 2");
    end

    rd_state_e         state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] regs [NREGS];

    logic [DATA_W-1:0] bus1;
    logic [DATA_W-1:0] bus2;
    logic [DATA_W-1:0] bus2_pre;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_flags;

    always_comb begin
        bus1 = '0;
        unique case (bus1_sel)
            BUS1_PC:  bus1 = DATA_W'(pc);
            BUS1_REG: bus1 = regs[reg_rd_sel];
            BUS1_MDR: bus1 = mdr;
            BUS1_SP:  bus1 = DATA_W'(sp);
        endcase
    end

    // BUS2 without the ALU leg, so ALU B never feeds back on itself.
    always_comb begin
        bus2_pre = '0;
        unique case (bus2_sel)
            BUS2_BUS1: bus2_pre = bus1;
            BUS2_MDR:  bus2_pre = mdr;
            default:   bus2_pre = '0;
        endcase
    end

    always_comb begin
        if (alu_b_sel && (bus2_sel != BUS2_ALU))
            alu_b = bus2_pre;
        else
            alu_b = regs[alu_b_reg_sel];
        bus2 = (bus2_sel == BUS2_ALU) ? alu_res : bus2_pre;
    end

    dp_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (alu_sel),
        .a      (bus1),
        .b      (alu_b),
        .result (alu_res),
        .flags  (alu_flags)
    );

    assign to_memory = bus1;
    assign stall     = mem_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RD_IDLE;
            mem_req   <= 1'b0;
            mdr_valid <= 1'b0;
            mdr       <= '0;
        end else begin
            mdr_valid <= 1'b0;
            unique case (state)
                RD_IDLE: begin
                    if (mem_rd) begin
                        state   <= RD_WAIT;
                        mem_req <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (mem_ack) begin
                        mdr       <= from_memory;
                        state     <= RD_IDLE;
                        mem_req   <= 1'b0;
                        mdr_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir        <= '0;
            address   <= '0;
            pc        <= '0;
            sp        <= SP_TOP;
            ccr       <= '0;
            stack_err <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (!mem_req) begin
            if (ir_load)
                ir <= bus2;
            if (mar_load)
                address <= bus2[ADDR_W-1:0];
            if (pc_load)
                pc <= pc_rel ? pc + mdr[ADDR_W-1:0]
                             : bus2[ADDR_W-1:0];
            else if (pc_inc)
                pc <= pc + ADDR_W'(1);
            if (reg_wr_en)
                regs[reg_wr_sel] <= bus2;
            if (ccr_load)
                ccr <= alu_flags;
            // Over/underflow leaves SP in place and latches the error.
            if (sp_push && !sp_pop) begin
                if (sp == '0)
                    stack_err <= 1'b1;
                else
                    sp <= sp - ADDR_W'(1);
            end else if (sp_pop && !sp_push) begin
                if (sp == SP_TOP)
                    stack_err <= 1'b1;
                else
                    sp <= sp + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_data_path_param.sv
// Bench for data_path_param: 8-bit and 16/12-bit instances driven
// in parallel, directed scenarios plus a randomized ALU/regfile model.
module tb_data_path_param;
    import dp_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ir_load, mar_load, pc_load, pc_inc, ccr_load, pc_rel;
    logic reg_wr_en, alu_b_sel, sp_push, sp_pop, mem_rd, mem_ack;
    logic [1:0] reg_wr_sel, reg_rd_sel, alu_b_reg_sel;
    logic [1:0] bus1_sel, bus2_sel;
    logic [3:0] alu_sel;
    logic [15:0] fm;

    logic [7:0] tm8, ir8, addr8, sp8;
    logic [3:0] ccr8;
    logic mreq8, stall8, mv8, err8;

    logic [15:0] tm16, ir16;
    logic [11:0] addr16, sp16;
    logic [3:0] ccr16;
    logic mreq16, stall16, mv16, err16;

    int passed = 0;
    int total = 0;

    logic [7:0] m_regs [4];
    logic [7:0] m_mdr;

    always #5 clk = ~clk;

    data_path_param u_dut8 (
        .clk(clk), .reset(reset),
        .ir_load(ir_load), .mar_load(mar_load),
        .pc_load(pc_load), .pc_inc(pc_inc),
        .ccr_load(ccr_load), .pc_rel(pc_rel),
        .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel),
        .reg_rd_sel(reg_rd_sel), .alu_b_reg_sel(alu_b_reg_sel),
        .bus1_sel(bus1_sel), .bus2_sel(bus2_sel),
        .alu_sel(alu_sel), .alu_b_sel(alu_b_sel),
        .sp_push(sp_push), .sp_pop(sp_pop),
        .mem_rd(mem_rd), .mem_ack(mem_ack),
        .from_memory(fm[7:0]), .to_memory(tm8),
        .mem_req(mreq8), .stall(stall8), .mdr_valid(mv8),
        .ir(ir8), .address(addr8), .sp(sp8),
        .ccr(ccr8), .stack_err(err8)
    );

    data_path_param #(.DATA_W(16), .ADDR_W(12)) u_dut16 (
        .clk(clk), .reset(reset),
        .ir_load(ir_load), .mar_load(mar_load),
        .pc_load(pc_load), .pc_inc(pc_inc),
        .ccr_load(ccr_load), .pc_rel(pc_rel),
        .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel),
        .reg_rd_sel(reg_rd_sel), .alu_b_reg_sel(alu_b_reg_sel),
        .bus1_sel(bus1_sel), .bus2_sel(bus2_sel),
        .alu_sel(alu_sel), .alu_b_sel(alu_b_sel),
        .sp_push(sp_push), .sp_pop(sp_pop),
        .mem_rd(mem_rd), .mem_ack(mem_ack),
        .from_memory(fm), .to_memory(tm16),
        .mem_req(mreq16), .stall(stall16), .mdr_valid(mv16),
        .ir(ir16), .address(addr16), .sp(sp16),
        .ccr(ccr16), .stack_err(err16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ir_load = 0; mar_load = 0; pc_load = 0; pc_inc = 0;
        ccr_load = 0; pc_rel = 0; reg_wr_en = 0; alu_b_sel = 0;
        sp_push = 0; sp_pop = 0; mem_rd = 0; mem_ack = 0;
        reg_wr_sel = 0; reg_rd_sel = 0; alu_b_reg_sel = 0;
        bus1_sel = BUS1_PC; bus2_sel = BUS2_ZERO; alu_sel = ALU_ADD;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
        step();
    endtask

    task automatic load_mdr(input logic [15:0] v);
        idle();
        mem_rd = 1;
        step();
        mem_rd = 0;
        mem_ack = 1;
        fm = v;
        step();
        mem_ack = 0;
        m_mdr = v[7:0];
    endtask

    task automatic set_reg(input logic [1:0] idx, input logic [7:0] v);
        load_mdr({8'h00, v});
        bus2_sel = BUS2_MDR;
        reg_wr_en = 1;
        reg_wr_sel = idx;
        step();
        idle();
        m_regs[idx] = v;
    endtask

    task automatic set_pc(input logic [15:0] v);
        load_mdr(v);
        bus2_sel = BUS2_MDR;
        pc_load = 1;
        step();
        idle();
    endtask

    // Reference ALU from signed/unsigned integer range rules.
    function automatic void ref_alu(
        input int op, input int a, input int b,
        output logic [7:0] r, output logic [3:0] f);
        int sa, sb, full, sfull;
        bit v, c;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        v = 0; c = 0; sfull = 0;
        case (op)
            0: begin full = a + b; sfull = sa + sb; c = full > 255; end
            1: begin full = a - b; sfull = sa - sb; c = a < b; end
            2: full = a & b;
            3: full = a | b;
            4: full = a ^ b;
            5: begin full = a + 1; sfull = sa + 1; c = full > 255; end
            6: begin full = a - 1; sfull = sa - 1; c = (a == 0); end
            default: full = a;
        endcase
        if (op == 0 || op == 1 || op == 5 || op == 6)
            v = (sfull > 127) || (sfull < -128);
        r = 8'(full & 255);
        f = {r[7], r == 8'h00, v, c};
    endfunction

    task automatic test_reset();
        do_reset();
        total++; if (ir8 !== 8'h00) $display("FAIL reset_ir got %h want 00", ir8); else passed++;
        total++; if (addr8 !== 8'h00) $display("FAIL reset_mar got %h want 00", addr8); else passed++;
        total++; if (sp8 !== 8'hFF) $display("FAIL reset_sp got %h want FF", sp8); else passed++;
        total++; if (sp16 !== 12'hFFF) $display("FAIL reset_sp16 got %h want FFF", sp16); else passed++;
        total++; if (ccr8 !== 4'h0) $display("FAIL reset_ccr got %b want 0000", ccr8); else passed++;
        total++; if ({err8, mreq8, stall8, mv8} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {err8, mreq8, stall8, mv8});
        else passed++;
        total++; if (tm8 !== 8'h00) $display("FAIL reset_pc got %h want 00", tm8); else passed++;
    endtask

    task automatic test_read();
        logic [7:0] exp_req [6];
        exp_req = '{8'h1, 8'h1, 8'h1, 8'h0, 8'h0, 8'h0};
        do_reset();
        bus1_sel = BUS1_MDR;
        mem_rd = 1;
        step();
        for (int c = 1; c <= 5; c++) begin
            mem_rd = (c == 1);
            mem_ack = (c == 3);
            fm = (c == 3) ? 16'h00A5 : 16'h0000;
            total++;
            if ({mreq8, stall8} !== {2{exp_req[c-1][0]}})
                $display("FAIL read_req c%0d got %b want %b", c, {mreq8, stall8}, {2{exp_req[c-1][0]}});
            else passed++;
            total++;
            if (mv8 !== (c == 4))
                $display("FAIL read_valid c%0d got %b want %b", c, mv8, c == 4);
            else passed++;
            if (c >= 4) begin
                total++;
                if (tm8 !== 8'hA5) $display("FAIL read_mdr c%0d got %h want A5", c, tm8);
                else passed++;
            end
            step();
        end
        mem_ack = 1;
        fm = 16'h0077;
        step();
        mem_ack = 0;
        total++;
        if ({tm8, mreq8, mv8} !== {8'hA5, 2'b00})
            $display("FAIL idle_ack got %h/%b%b want A5/00", tm8, mreq8, mv8);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        set_pc(16'h0020);
        load_mdr(16'h003C);
        bus2_sel = BUS2_MDR;
        ir_load = 1;
        step();
        idle();
        mem_rd = 1;
        step();
        mem_rd = 0;
        bus2_sel = BUS2_MDR;
        ir_load = 1; pc_inc = 1; mar_load = 1; sp_push = 1;
        step();
        step();
        mem_ack = 1;
        fm = 16'h005A;
        step();
        mem_ack = 0;
        total++;
        if ({ir8, tm8, addr8, sp8} !== {8'h3C, 8'h20, 8'h00, 8'hFF})
            $display("FAIL stall_hold got %h %h %h %h want 3C 20 00 FF", ir8, tm8, addr8, sp8);
        else passed++;
        step();
        total++;
        if ({ir8, tm8, addr8, sp8} !== {8'h5A, 8'h21, 8'h5A, 8'hFE})
            $display("FAIL stall_release got %h %h %h %h want 5A 21 5A FE", ir8, tm8, addr8, sp8);
        else passed++;
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        set_pc(16'h0010);
        load_mdr(16'h00FC);
        pc_load = 1; pc_rel = 1; pc_inc = 1;
        step();
        idle();
        total++; if (tm8 !== 8'h0C) $display("FAIL branch_rel got %h want 0C", tm8); else passed++;
        set_pc(16'h00FE);
        pc_inc = 1;
        repeat (3) step();
        idle();
        total++; if (tm8 !== 8'h01) $display("FAIL pc_wrap got %h want 01", tm8); else passed++;
    endtask

    task automatic test_stack();
        do_reset();
        sp_pop = 1;
        step();
        idle();
        total++; if ({sp8, err8} !== {8'hFF, 1'b1})
            $display("FAIL pop_empty got %h/%b want FF/1", sp8, err8);
        else passed++;
        sp_push = 1;
        repeat (255) step();
        total++; if ({sp8, err8} !== {8'h00, 1'b1})
            $display("FAIL push_full got %h/%b want 00/1", sp8, err8);
        else passed++;
        do_reset();
        sp_push = 1;
        repeat (255) step();
        total++; if ({sp8, err8} !== {8'h00, 1'b0})
            $display("FAIL push_to_zero got %h/%b want 00/0", sp8, err8);
        else passed++;
        step();
        total++; if ({sp8, err8} !== {8'h00, 1'b1})
            $display("FAIL push_over got %h/%b want 00/1", sp8, err8);
        else passed++;
        do_reset();
        sp_push = 1; sp_pop = 1;
        step();
        idle();
        total++; if ({sp8, err8} !== {8'hFF, 1'b0})
            $display("FAIL push_pop got %h/%b want FF/0", sp8, err8);
        else passed++;
    endtask

    task automatic test_alu();
        do_reset();
        set_reg(2'd1, 8'h80);
        set_reg(2'd2, 8'h80);
        bus1_sel = BUS1_REG; reg_rd_sel = 1;
        alu_b_reg_sel = 2; alu_sel = ALU_ADD;
        bus2_sel = BUS2_ALU; reg_wr_en = 1; reg_wr_sel = 3;
        ccr_load = 1;
        step();
        idle();
        bus1_sel = BUS1_REG; reg_rd_sel = 3;
        #1;
        total++; if (tm8 !== 8'h00) $display("FAIL alu_r3 got %h want 00", tm8); else passed++;
        total++; if (ccr8 !== 4'b0111) $display("FAIL alu_ccr got %b want 0111", ccr8); else passed++;
        set_reg(2'd1, 8'h11);
        set_reg(2'd2, 8'h22);
        bus1_sel = BUS1_REG; reg_rd_sel = 1;
        alu_b_reg_sel = 2; alu_b_sel = 1; alu_sel = ALU_ADD;
        bus2_sel = BUS2_ALU; reg_wr_en = 1; reg_wr_sel = 0;
        step();
        idle();
        bus1_sel = BUS1_REG; reg_rd_sel = 0;
        #1;
        total++; if (tm8 !== 8'h33) $display("FAIL loop_guard got %h want 33", tm8); else passed++;
    endtask

    task automatic test_random();
        int op, rs, rb, rw, b1, b2, ab;
        logic [7:0] a, b, r, wr, m_pc, m_sp;
        logic [3:0] f;
        do_reset();
        m_pc = 8'h00;
        m_sp = 8'hFF;
        for (int i = 0; i < 4; i++)
            set_reg(2'(i), 8'($urandom_range(0, 255)));
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 7);
            rs = $urandom_range(0, 3);
            rb = $urandom_range(0, 3);
            rw = $urandom_range(0, 3);
            b1 = $urandom_range(0, 3);
            b2 = $urandom_range(0, 3);
            ab = $urandom_range(0, 1);
            a = (b1 == 0) ? m_pc : (b1 == 1) ? m_regs[rs] :
                (b1 == 2) ? m_mdr : m_sp;
            if (ab == 1 && b2 != 0)
                b = (b2 == 1) ? a : (b2 == 2) ? m_mdr : 8'h00;
            else
                b = m_regs[rb];
            ref_alu(op, int'(a), int'(b), r, f);
            wr = (b2 == 0) ? r : (b2 == 1) ? a : (b2 == 2) ? m_mdr : 8'h00;
            idle();
            alu_sel = 4'(op); reg_rd_sel = 2'(rs);
            alu_b_reg_sel = 2'(rb); reg_wr_sel = 2'(rw);
            bus1_sel = 2'(b1); bus2_sel = 2'(b2); alu_b_sel = ab[0];
            reg_wr_en = 1; ccr_load = 1;
            step();
            m_regs[rw] = wr;
            idle();
            bus1_sel = BUS1_REG; reg_rd_sel = 2'(rw);
            #1;
            total++;
            if (ccr8 !== f)
                $display("FAIL rand_ccr n%0d op%0d a=%h b=%h got %b want %b", n, op, a, b, ccr8, f);
            else passed++;
            total++;
            if (tm8 !== wr)
                $display("FAIL rand_reg n%0d op%0d got %h want %h", n, op, tm8, wr);
            else passed++;
        end
    endtask

    task automatic test_wide();
        do_reset();
        set_pc(16'h0FFF);
        #1;
        total++; if (tm16 !== 16'h0FFF) $display("FAIL wide_pc got %h want 0FFF", tm16); else passed++;
        pc_inc = 1;
        step();
        idle();
        total++; if (tm16 !== 16'h0000) $display("FAIL wide_wrap got %h want 0000", tm16); else passed++;
        load_mdr(16'hFFFE);
        pc_load = 1; pc_rel = 1;
        step();
        idle();
        total++; if (tm16 !== 16'h0FFE) $display("FAIL wide_rel got %h want 0FFE", tm16); else passed++;
        mem_rd = 1;
        step();
        mem_rd = 0;
        total++; if (mreq16 !== 1'b1) $display("FAIL wide_wait got %b want 1", mreq16); else passed++;
        #2;
        reset = 1;
        #1;
        total++; if (mreq16 !== 1'b0) $display("FAIL async_reset got %b want 0", mreq16); else passed++;
        @(posedge clk);
        #1;
        reset = 0;
        mem_ack = 1;
        fm = 16'h1234;
        bus1_sel = BUS1_MDR;
        step();
        mem_ack = 0;
        total++;
        if ({tm16, mreq16, mv16} !== {16'h0000, 2'b00})
            $display("FAIL late_ack got %h/%b%b want 0000/00", tm16, mreq16, mv16);
        else passed++;
    endtask

    initial begin
        fm = 16'h0000;
        m_mdr = 8'h00;
        for (int i = 0; i < 4; i++)
            m_regs[i] = 8'h00;
        idle();
        test_reset();
        test_read();
        test_stall();
        test_branch();
        test_stack();
        test_alu();
        test_random();
        test_wide();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
